relu_out_serializer: RTL
========================

Name: relu_out_serializer

Overview:
- Consumer side of the ReLU output interface.
- Captures each CO-channel activation vector on a relu_valid pulse and buffers it in a small vector FIFO.
- Requantizes each channel (right shift, then unsigned saturation) and streams the channels one per beat over a valid/ready handshake toward the output buffer or writer.
- Sits directly after relu in the cnn_core pipeline. It absorbs the ReLU's lack of backpressure and flags any vector it is forced to drop.

Parameters:
- CO, 16, number of channels per input vector.
- AB_BW, 32, bits per channel in the input vector (signed two's complement).
- OUT_BW, 8, bits per output beat (unsigned).
- FRAC_SHIFT, 0, arithmetic right shift applied before saturation.
- DEPTH, 4, vector FIFO depth (any integer >= 2, not restricted to powers of two).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- relu_valid  input  1  single-cycle qualifier for relu_in; the source has no backpressure.
- relu_in  input  CO*AB_BW  activation vector; channel k occupies bits [k*AB_BW +: AB_BW].
- o_valid  output  1  beat valid.
- o_ready  input  1  downstream accept.
- o_data  output  OUT_BW  requantized channel value.
- o_ch  output  clog2(CO)  channel index of the current beat.
- o_last  output  1  high on the channel CO-1 beat.
- overflow  output  1  sticky flag: at least one vector was dropped.
- busy  output  1  high when the FIFO is non-empty or o_valid is high.

Behaviour:
- Reset values, applied immediately on assertion:
  - o_valid=0, o_data=0, o_ch=0, o_last=0, overflow=0, busy=0.
  - FIFO pointers and count cleared; FSM returns to IDLE.
  - Reset mid-transfer discards the FIFO contents and the in-flight vector. No residual beats appear after release.
- FIFO write:
  - A vector is written on a rising edge where relu_valid=1 and (count<DEPTH, or a pop occurs on the same edge).
  - Otherwise the vector is dropped and overflow is set to 1. overflow clears only on reset.
- Pop: the FIFO head is moved into the holding register cur in either case below:
  - FSM in IDLE and count>0.
  - FSM in SEND and the o_last beat is accepted (o_valid&o_ready&o_last) and count>0.
- FSM states:
  - IDLE -> SEND on pop. Sets o_valid=1 and o_ch=0.
  - SEND: channel counter advances on o_valid&o_ready.
    - Non-last beat accepted: o_ch <= o_ch+1.
    - Last beat accepted, count>0: pop, stay in SEND, o_ch <= 0. No bubble between vectors.
    - Last beat accepted, count=0: go to IDLE, o_valid <= 0.
- Latency: with relu_valid sampled at edge t into an idle, empty block, o_valid=1 with o_ch=0 holds after edge t+1, i.e. 2 cycles from presenting relu_valid.
- Handshake rules:
  - o_data, o_ch and o_last are stable while o_valid=1 and o_ready=0.
  - o_valid never drops without acceptance except on reset.
  - o_ready is ignored while o_valid=0.
- Arithmetic, per channel:
  - v = signed(cur[k]) >>> FRAC_SHIFT.
  - v<0 gives 0.
  - v > 2^OUT_BW-1 gives 2^OUT_BW-1.
  - Otherwise o_data = v[OUT_BW-1:0].
- Computation: registered from cur and the channel index. Must meet the stated 2-cycle latency and the no-bubble rule; one output-register stage is acceptable if the index mux is pipelined.
- Capacity: one vector in cur plus DEPTH in the FIFO.
- Simultaneous push with last-beat pop when count=DEPTH: the write is accepted and count is unchanged.

Test Plan:
Bench overrides: CO=4, AB_BW=16, OUT_BW=8, DEPTH=2, FRAC_SHIFT=2.
- Basic vector:
  - Stimulus: one vector {ch0=40, ch1=1023, ch2=0, ch3=3}, o_ready=1.
  - Required: beats 10, 255, 0, 0 with o_ch 0..3 on consecutive cycles; o_last only on ch3.
  - Required: first o_valid exactly 2 cycles after relu_valid; busy low afterward.
- Backpressure:
  - Stimulus: same vector; o_ready=0 for 3 cycles while o_ch=1.
  - Required: o_data=255 and o_ch=1 held for all 3 cycles, then ch2 and ch3 follow.
- Back-to-back vectors:
  - Stimulus: two vectors on consecutive cycles, o_ready=1.
  - Required: 8 contiguous beats with no o_valid gap between o_ch=3 and the next o_ch=0.
- Overflow:
  - Stimulus: o_ready=0; four vectors on consecutive cycles.
  - Required: the first three are retained and the fourth dropped; overflow=1 from the edge after the fourth relu_valid.
  - Then raise o_ready: exactly 12 beats, and overflow stays 1.
- Negative input and full push/pop:
  - Stimulus: ch0=-5.
  - Required: o_data=0.
  - Stimulus: FIFO full, relu_valid coincident with the last-beat accept.
  - Required: the vector is accepted and overflow stays 0.
- Reset mid-transfer:
  - Stimulus: reset pulsed during the ch2 beat with one vector queued.
  - Required: o_valid=0 immediately and overflow=0; after release, no beats until a new relu_valid.

Source files
------------

// File: rtl/relu_out_serializer.sv
// ReLU output serializer: captures CO-channel activation vectors into a small FIFO,
// requantizes each channel (shift + unsigned saturation) and streams one channel per beat.
module relu_out_serializer #(
   parameter int CO         = 16,
   parameter int AB_BW      = 32,
   parameter int OUT_BW     = 8,
   parameter int FRAC_SHIFT = 0,
   parameter int DEPTH      = 4,
   localparam int CHW       = (CO > 1) ? $clog2(CO) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                relu_valid,
   input  logic [CO*AB_BW-1:0] relu_in,
   output logic                o_valid,
   input  logic                o_ready,
   output logic [OUT_BW-1:0]   o_data,
   output logic [CHW-1:0]      o_ch,
   output logic                o_last,
   output logic                overflow,
   output logic                busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t              r_state, w_next;
   logic [CO*AB_BW-1:0] r_mem [DEPTH];
   logic [CO*AB_BW-1:0] r_cur;
   logic [PW-1:0]       r_wptr, r_rptr;
   logic [CW-1:0]       r_count;
   logic [CHW-1:0]      r_ch;
   logic [OUT_BW-1:0]   r_data;
   logic                r_last, r_ovf;

   logic                w_nonempty, w_accept, w_last_acc, w_pop, w_push;
   logic [CHW-1:0]      w_nch;
   logic [CO*AB_BW-1:0] w_head;

   function automatic logic [OUT_BW-1:0] f_requant(input logic [AB_BW-1:0] x);
      logic signed [AB_BW-1:0] v;
      v = $signed(x) >>> FRAC_SHIFT;
      if (v < 0) return '0;
      if ((v >> OUT_BW) != '0) return '1;
      return OUT_BW'($unsigned(v));
   endfunction

   assign w_head = r_mem[r_rptr];
   assign w_nch  = r_ch + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_nonempty = (r_count != '0);
      w_accept   = (r_state == S_SEND) && o_ready;
      w_last_acc = w_accept && r_last;
      case (r_state)
         S_IDLE: begin
            if (w_nonempty) begin
               w_pop  = 1'b1;
               w_next = S_SEND;
            end
         end
         S_SEND: begin
            if (w_last_acc) begin
               if (w_nonempty) w_pop  = 1'b1;
               else            w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // A pop on the same edge frees a slot, so a full FIFO still accepts the write
      w_push = relu_valid && ((r_count < CW'(DEPTH)) || w_pop);
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= relu_in;
      if (w_pop)  r_cur <= w_head;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ch    <= '0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push)          r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         else if (relu_valid) r_ovf  <= 1'b1;

         // Output register is loaded from the vector being popped, hiding the cur-load cycle
         if (w_pop) begin
            r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            r_ch   <= '0;
            r_data <= f_requant(w_head[AB_BW-1:0]);
            r_last <= (CO == 1);
         end else if (w_accept && !r_last) begin
            r_ch   <= w_nch;
            r_data <= f_requant(r_cur[int'(w_nch)*AB_BW +: AB_BW]);
            r_last <= (w_nch == CHW'(CO - 1));
         end else if (w_last_acc) begin
            r_last <= 1'b0;
         end

         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   assign o_valid  = (r_state == S_SEND);
   assign o_data   = r_data;
   assign o_ch     = r_ch;
   assign o_last   = r_last;
   assign overflow = r_ovf;
   assign busy     = (r_count != '0) || o_valid;

endmodule
